count_arbiter: RTL and testbench

//  Shares one up/down terminal-count counter among NUM_REQ requesters.

---
 rtl/count_arbiter_if.sv | 27 ++
 rtl/count_arbiter.sv | 155 +++++++++++++++
 tb/tb_count_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_arbiter_if.sv
// rtl/count_arbiter_if.sv - requester-side bus of the shared terminal-count counter arbiter
interface count_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_len;
  logic [NUM_REQ-1:0]       req_dir;
  logic                     pause;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         count;
  logic                     tc;
  logic [NUM_REQ-1:0]       done;

  // Arbiter side: takes requests, drives ownership and counter status.
  modport slave (
    input  req, req_len, req_dir, pause,
    output grant, busy, count, tc, done
  );

  // Client side: issues requests, observes ownership and counter status.
  modport master (
    output req, req_len, req_dir, pause,
    input  grant, busy, count, tc, done
  );
endinterface

// File: rtl/count_arbiter.sv
// rtl/count_arbiter.sv - round-robin arbiter sharing one up/down terminal-count counter
module count_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  count_arbiter_if.slave io_bus
);

  localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   r_gidx;
  logic [PTR_W-1:0]   w_gidx_nxt;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   w_len_nxt;
  logic               r_dir;
  logic               w_dir_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;

  logic               w_sel_found;
  logic [PTR_W-1:0]   w_sel_idx;
  logic [CNT_W-1:0]   w_load_len;
  logic               w_load_dir;
  logic               w_tc;
  logic [NUM_REQ-1:0] w_done;

  // Requester index base+off folded back into 0..NUM_REQ-1 (off < NUM_REQ).
  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end
    return PTR_W'(s);
  endfunction

  // Round-robin pick: first requester at or after the pointer wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_sel_found && io_bus.req[wrap_idx(int'(r_ptr), k)]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = wrap_idx(int'(r_ptr), k);
      end
    end
  end

  // Owner's length/direction as seen during LOAD; captured into r_len/r_dir there.
  assign w_load_len = io_bus.req_len[int'(r_gidx)*CNT_W +: CNT_W];
  assign w_load_dir = io_bus.req_dir[r_gidx];

  // Terminal count is only meaningful while running; len is never 0 in RUN.
  assign w_tc = (r_state == S_RUN) &&
                (r_dir ? (r_count == (r_len - CNT_ONE)) : (r_count == '0));

  assign w_done = (r_state == S_DONE) ? r_grant : '0;

  assign io_bus.grant = r_grant;
  assign io_bus.busy  = (r_state != S_IDLE);
  assign io_bus.count = r_count;
  assign io_bus.tc    = w_tc;
  assign io_bus.done  = w_done;

  // Next-state and datapath updates; every register holds unless its state changes it.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    w_len_nxt   = r_len;
    w_dir_nxt   = r_dir;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_gidx_nxt  = w_sel_idx;
          w_grant_nxt = NUM_REQ'(1) << w_sel_idx;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_len_nxt = w_load_len;
        w_dir_nxt = w_load_dir;
        if (w_load_len == '0) begin
          // Zero-length request completes without ever entering RUN.
          w_count_nxt = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_count_nxt = w_load_dir ? '0 : (w_load_len - CNT_ONE);
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!io_bus.pause) begin
          if (w_tc) begin
            w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = r_dir ? (r_count + CNT_ONE) : (r_count - CNT_ONE);
          end
        end
      end
      S_DONE: begin
        // Finished owner drops to lowest priority for the next pick.
        w_ptr_nxt   = (r_gidx == PTR_LAST) ? '0 : (r_gidx + PTR_ONE);
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_len   <= '0;
      r_dir   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
      r_len   <= w_len_nxt;
      r_dir   <= w_dir_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_count_arbiter.sv
// tb/tb_count_arbiter.sv - directed self-checking bench for count_arbiter
module tb_count_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;

  logic clk;
  logic reset;

  count_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  count_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  typedef struct {
    int idx;
    int len;
    bit dir;
    int exp_done;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.req   = '0;
    bus.pause = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One isolated operation; expected counts come from the length/direction of the vector.
  task automatic run_op(input vec_t v);
    logic [NUM_REQ-1:0] oh;
    int cyc;
    int k;
    oh = NUM_REQ'(1) << v.idx;
    bus.req                        = oh;
    bus.req_len[v.idx*CNT_W +: CNT_W] = CNT_W'(v.len);
    bus.req_dir[v.idx]             = v.dir;
    check("idle_busy", 32'(bus.busy), 32'd0);
    tick();
    cyc = 1;
    check("grant_t1", 32'(bus.grant), 32'(oh));
    while (cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 2) begin
        // Owner changes its mind after LOAD: must have no effect.
        bus.req                        = '0;
        bus.req_len[v.idx*CNT_W +: CNT_W] = ~CNT_W'(v.len);
        bus.req_dir[v.idx]             = ~v.dir;
      end
      if (bus.done != '0) break;
      k = cyc - 2;
      check("run_count", 32'(bus.count), v.dir ? 32'(k) : 32'(v.len - 1 - k));
      check("run_tc", 32'(bus.tc), 32'(k == v.len - 1));
    end
    check("done_cycle", 32'(cyc), 32'(v.exp_done));
    check("done_val", 32'(bus.done), 32'(oh));
    check("done_grant", 32'(bus.grant), 32'(oh));
    check("done_tc", 32'(bus.tc), 32'd0);
    tick();
    check("post_busy", 32'(bus.busy), 32'd0);
    check("post_grant", 32'(bus.grant), 32'd0);
    check("post_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] got[$];
    logic [NUM_REQ-1:0] rr_exp[5];
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus.req     = '0;
    bus.req_len = '0;
    bus.req_dir = '0;
    bus.pause   = 1'b0;

    vecs[0] = '{idx: 0, len: 3,   dir: 1'b1, exp_done: 5};
    vecs[1] = '{idx: 1, len: 4,   dir: 1'b0, exp_done: 6};
    vecs[2] = '{idx: 2, len: 0,   dir: 1'b1, exp_done: 2};
    vecs[3] = '{idx: 3, len: 1,   dir: 1'b0, exp_done: 3};
    vecs[4] = '{idx: 0, len: 1,   dir: 1'b1, exp_done: 3};
    vecs[5] = '{idx: 2, len: 7,   dir: 1'b1, exp_done: 9};
    vecs[6] = '{idx: 1, len: 0,   dir: 1'b0, exp_done: 2};
    vecs[7] = '{idx: 3, len: 255, dir: 1'b0, exp_done: 257};
    vecs[8] = '{idx: 0, len: 255, dir: 1'b1, exp_done: 257};

    // Reset state
    tick();
    tick();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_tc",    32'(bus.tc),    32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i]);
      tick();
    end

    // Round robin with all four holding req, len=2 up.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_len[i*CNT_W +: CNT_W] = 8'd2;
      bus.req_dir[i]                = 1'b1;
    end
    bus.req   = 4'b1111;
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;
    for (int c = 0; c < 100 && got.size() < 5; c++) begin
      tick();
      if (bus.done != '0) got.push_back(bus.done);
    end
    bus.req = '0;
    check("rr_ndone", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("rr_order", (i < got.size()) ? 32'(got[i]) : 32'hdead, 32'(rr_exp[i]));
    end
    tick();
    tick();

    // Pause for 3 cycles while count=2, len=5 up.
    do_reset();
    bus.req_len[0 +: CNT_W] = 8'd5;
    bus.req_dir[0]          = 1'b1;
    bus.req                 = 4'b0001;
    tick();                                   // t+1
    bus.req = '0;
    tick();                                   // t+2
    tick();                                   // t+3
    tick();                                   // t+4
    check("pz_cnt_t4", 32'(bus.count), 32'd2);
    bus.pause = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      tick();
      check("pz_hold", 32'(bus.count), 32'd2);
      check("pz_nodone", 32'(bus.done), 32'd0);
    end
    bus.pause = 1'b0;
    tick();                                   // t+8
    check("pz_cnt_t8", 32'(bus.count), 32'd3);
    tick();                                   // t+9
    check("pz_cnt_t9", 32'(bus.count), 32'd4);
    check("pz_tc_t9", 32'(bus.tc), 32'd1);
    tick();                                   // t+10
    check("pz_done_t10", 32'(bus.done), 32'd1);
    tick();

    // Pause asserted at terminal count: tc stays high, done waits.
    do_reset();
    bus.req_len[0 +: CNT_W] = 8'd2;
    bus.req                 = 4'b0001;
    tick();
    bus.req = '0;
    tick();
    tick();                                   // t+3, count 1, tc
    check("ptc_tc", 32'(bus.tc), 32'd1);
    bus.pause = 1'b1;
    tick();
    check("ptc_cnt", 32'(bus.count), 32'd1);
    check("ptc_tc_hold", 32'(bus.tc), 32'd1);
    check("ptc_nodone", 32'(bus.done), 32'd0);
    bus.pause = 1'b0;
    tick();
    check("ptc_done", 32'(bus.done), 32'd1);
    tick();

    // Reset mid-RUN: operation dropped, pointer back to 0.
    do_reset();
    run_op('{idx: 2, len: 3, dir: 1'b1, exp_done: 5});   // ptr now 3
    bus.req_len[0 +: CNT_W] = 8'd8;
    bus.req_dir[0]          = 1'b1;
    bus.req                 = 4'b0001;
    tick();                                   // t+1
    for (int i = 2; i <= 5; i++) tick();      // t+5, count 3
    check("mr_cnt3", 32'(bus.count), 32'd3);
    reset = 1'b1;
    bus.req_len[2*CNT_W +: CNT_W] = 8'd2;
    bus.req_len[3*CNT_W +: CNT_W] = 8'd2;
    bus.req = 4'b1100;
    tick();
    check("mr_grant", 32'(bus.grant), 32'd0);
    check("mr_busy",  32'(bus.busy),  32'd0);
    check("mr_count", 32'(bus.count), 32'd0);
    check("mr_done",  32'(bus.done),  32'd0);
    reset = 1'b0;
    tick();
    check("mr_regrant", 32'(bus.grant), 32'b0100);
    bus.req = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
